// File: rtl/writeback_pkg.sv
// writeback_pkg: shared encodings, sizes and condition-code helper for the writeback slice
package writeback_pkg;
  localparam int NUM_REGS = 8;
  localparam int DATA_W = 16;
  localparam int IDX_W = 3;
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC = 2'd2;
  localparam logic [1:0] WB_NPC = 2'd3;
  localparam int PSR_N = 2;
  localparam int PSR_Z = 1;
  localparam int PSR_P = 0;
  function automatic logic [2:0] cond_codes(input logic [DATA_W-1:0] v);
    logic [2:0] cc;
    cc = '0;
    cc[PSR_N] = v[DATA_W-1];
    cc[PSR_Z] = (v == '0);
    cc[PSR_P] = !v[DATA_W-1] && (v != '0);
    return cc;
  endfunction
endpackage

// File: rtl/writeback_reg_file.sv
// wb_reg_file: eight-entry register file, one synchronous write port, two asynchronous read ports
module wb_reg_file
  import writeback_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [IDX_W-1:0]  ra1,
  input  logic [IDX_W-1:0]  ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[wa] = wd;
  end
  always_ff @(posedge clock) begin
    if (reset) regs_q <= '0;
    else regs_q <= regs_d;
  end
  // No bypass: reads see the stored value until the write edge has passed
  assign rd1 = regs_q[ra1];
  assign rd2 = regs_q[ra2];
endmodule

// File: rtl/writeback.sv
// writeback: selects the write-back source, updates the register file and the NZP condition codes
module writeback
  import writeback_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_writeback,
  input  logic [DATA_W-1:0] npc,
  input  logic [1:0]        W_control_in,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] pcout,
  input  logic [DATA_W-1:0] memout,
  input  logic [IDX_W-1:0]  sr1,
  input  logic [IDX_W-1:0]  sr2,
  input  logic [IDX_W-1:0]  dr,
  output logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] d2,
  output logic [2:0]        psr
);
  logic [DATA_W-1:0] wdata;
  logic [2:0] psr_q, psr_d;
  always_comb begin
    wdata = (W_control_in == WB_ALU) ? aluout :
            (W_control_in == WB_MEM) ? memout :
            (W_control_in == WB_PC)  ? pcout : npc;
    psr_d = enable_writeback ? cond_codes(wdata) : psr_q;
  end
  always_ff @(posedge clock) begin
    if (reset) psr_q <= '0;
    else psr_q <= psr_d;
  end
  assign psr = psr_q;
  wb_reg_file u_rf (
    .clock(clock),
    .reset(reset),
    .we(enable_writeback),
    .wa(dr),
    .wd(wdata),
    .ra1(sr1),
    .ra2(sr2),
    .rd1(d1),
    .rd2(d2)
  );
endmodule

// File: tb/tb_writeback.sv
// tb_writeback: directed scoreboard bench for writeback
module tb_writeback;
  logic clock = 1'b0;
  logic reset, enable_writeback;
  logic [15:0] npc, aluout, pcout, memout;
  logic [1:0] W_control_in;
  logic [2:0] sr1, sr2, dr;
  logic [15:0] d1, d2;
  logic [2:0] psr;
  logic [15:0] exp_q[$];
  logic [15:0] m_regs[8];
  logic [2:0] m_psr;
  int pass_cnt = 0;
  int total = 0;

  writeback dut (
    .clock(clock), .reset(reset), .enable_writeback(enable_writeback),
    .npc(npc), .W_control_in(W_control_in), .aluout(aluout), .pcout(pcout),
    .memout(memout), .sr1(sr1), .sr2(sr2), .dr(dr), .d1(d1), .d2(d2), .psr(psr)
  );

  always #5 clock = ~clock;

  function automatic logic [2:0] ref_cc(input logic [15:0] v);
    if (v[15]) return 3'b100;
    if (v == 16'h0000) return 3'b010;
    return 3'b001;
  endfunction

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic push(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    total++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) pass_cnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic wr(input logic [1:0] ctl, input logic [2:0] d, input logic [15:0] v);
    aluout = 16'h1111; memout = 16'h2222; pcout = 16'h4444; npc = 16'h6666;
    case (ctl)
      2'd0: aluout = v;
      2'd1: memout = v;
      2'd2: pcout = v;
      default: npc = v;
    endcase
    W_control_in = ctl; dr = d; enable_writeback = 1'b1;
    step();
    enable_writeback = 1'b0;
    m_regs[d] = v;
    m_psr = ref_cc(v);
  endtask

  initial begin
    reset = 1'b1; enable_writeback = 1'b0; W_control_in = 2'd0;
    npc = '0; aluout = '0; pcout = '0; memout = '0; sr1 = 3'd0; sr2 = 3'd7; dr = 3'd0;
    step();
    push(16'h0000); check("reset_held_d1", d1);
    push(16'h0000); check("reset_held_d2", d2);
    step();
    reset = 1'b0;
    #1;
    push(16'h0000); check("reset_d1", d1);
    push(16'h0000); check("reset_d2", d2);
    push(16'h0000); check("reset_psr", {13'b0, psr});

    wr(2'd0, 3'd3, 16'h1234);
    push(16'h0001); check("first_write_onehot", 16'($countones(psr)));
    sr1 = 3'd3; #1;
    push(16'h1234); check("alu_src_d1", d1);
    push(16'h0001); check("alu_src_psr", {13'b0, psr});
    wr(2'd1, 3'd4, 16'h8001);
    sr2 = 3'd4; #1;
    push(16'h8001); check("mem_src_d2", d2);
    push(16'h0004); check("mem_src_psr", {13'b0, psr});

    wr(2'd3, 3'd5, 16'h0000);
    sr1 = 3'd5; #1;
    push(16'h0000); check("npc_zero_d1", d1);
    push(16'h0002); check("npc_zero_psr", {13'b0, psr});
    wr(2'd2, 3'd6, 16'h3000);
    sr1 = 3'd6; #1;
    push(16'h3000); check("pc_src_d1", d1);
    push(16'h0001); check("pc_src_psr", {13'b0, psr});

    wr(2'd0, 3'd2, 16'h00AA);
    sr1 = 3'd2; dr = 3'd2; W_control_in = 2'd0; aluout = 16'h0055; enable_writeback = 1'b1;
    #1;
    push(16'h00AA); check("no_bypass_old", d1);
    step();
    enable_writeback = 1'b0; aluout = 16'hFFFF;
    #1;
    push(16'h0055); check("after_edge_new", d1);
    step();
    push(16'h0055); check("hold_reg", d1);
    push(16'h0001); check("hold_psr", {13'b0, psr});

    wr(2'd0, 3'd1, 16'h7FFF);
    sr1 = 3'd1; #1;
    push(16'h7FFF); check("pre_reset_r1", d1);
    reset = 1'b1; enable_writeback = 1'b1; aluout = 16'h8000; dr = 3'd1; W_control_in = 2'd0;
    step();
    reset = 1'b0; enable_writeback = 1'b0;
    #1;
    push(16'h0000); check("reset_prio_r1", d1);
    push(16'h0000); check("reset_prio_psr", {13'b0, psr});
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;

    for (int i = 0; i < 8; i++) begin
      wr(2'(i % 4), 3'(i), 16'hA000 + 16'(i));
      push({13'b0, m_psr}); check("sweep_psr", {13'b0, psr});
    end
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i); sr2 = 3'(7 - i); #1;
      push(m_regs[i]); check("sweep_d1", d1);
      push(m_regs[7 - i]); check("sweep_d2", d2);
      sr2 = 3'(i); #1;
      push(d1 === d2 ? 16'h0001 : 16'h0000);
      push(16'h0001); check("same_idx_equal", exp_q.pop_front());
      push(16'hA000 + 16'(i)); check("same_idx_d2", d2);
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 clock  input  1  single clock for the whole block; all state updates on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 enable_writeback  input  1  register-file write and PSR update enable.
REQ-004 npc  input  16  next-PC value, write source 3.
REQ-005 W_control_in  input  2  write-data source select.
REQ-006 aluout  input  16  ALU result, write source 0.
REQ-007 pcout  input  16  PC-relative address result, write source 2.
REQ-008 memout  input  16  memory load data, write source 1.
REQ-009 sr1  input  3  read-port-1 register index.
REQ-010 sr2  input  3  read-port-2 register index.
REQ-011 dr  input  3  destination register index.
REQ-012 d1  output  16  contents of R[sr1].
REQ-013 d2  output  16  contents of R[sr2].
REQ-014 psr  output  3  condition codes {N,Z,P}, bit 2 = N.

Function
REQ-015 The block SHALL hold eight 16-bit general registers R0..R7.
REQ-016 Write-data mux, combinational: W_control_in 0 -> aluout, 1 -> memout, 2 -> pcout, 3 -> npc. All codes are legal; there is no reserved value.
REQ-017 When enable_writeback=1 at a rising edge with reset=0, R[dr] SHALL load the muxed data. The write latency is 1 cycle.
REQ-018 When enable_writeback=0, the registers and psr SHALL hold their values. Changes on W_control_in, dr or the data inputs SHALL have no effect.
REQ-019 Reads SHALL be combinational: d1=R[sr1] and d2=R[sr2], both valid in the same cycle the index is presented.
REQ-020 There is no write-to-read bypass. If sr1 or sr2 equals dr during a write cycle, the output SHALL show the old value until after the edge, then the new value.
REQ-021 sr1=sr2 SHALL drive identical values on d1 and d2.
REQ-022 On each enabled write, psr SHALL register in the same edge:
- 3'b100 if data[15]=1;
- 3'b010 if data=16'h0000;
- 3'b001 otherwise.
REQ-023 Exactly one psr bit SHALL be set after the first enabled write following reset.
REQ-024 psr SHALL reflect the most recent enabled write only. It is not recomputed when a register is read.
REQ-025 Arithmetic: none. The data path is 16-bit pass-through with no width extension or truncation.

Reset
REQ-026 reset=1 at a rising edge SHALL clear R0..R7 to 16'h0000 and psr to 3'b000.
REQ-027 Reset SHALL take priority over a simultaneous enable_writeback; no write occurs in that cycle.
REQ-028 While reset is held, d1 and d2 SHALL read 16'h0000 from the cycle after the first reset edge.
REQ-029 The first write SHALL take effect on the first edge where reset=0 and enable_writeback=1.

Structure
REQ-030 The shared package SHALL define:
- the W_control encoding constants (WB_ALU=0, WB_MEM=1, WB_PC=2, WB_NPC=3);
- the register count (8) and data width (16);
- the psr bit positions (N=2, Z=1, P=0).
REQ-031 The register array SHALL live in one sub-module, wb_reg_file, with one write port and two asynchronous read ports. The source mux and psr logic stay in writeback.
REQ-032 psr SHALL be a flop; d1 and d2 SHALL have no output registers.

Verification
REQ-033 Reset, then sr1=0, sr2=7 -> d1=d2=16'h0000 and psr=3'b000.
REQ-034 Source select: write aluout=16'h1234, W_control_in=0, dr=3; next cycle sr1=3 -> d1=16'h1234, psr=3'b001.
- Repeat with memout=16'h8001 (ctl 1, dr=4) -> d2=16'h8001 at sr2=4, psr=3'b100.
REQ-035 Zero and source 3: npc=16'h0000, W_control_in=3, dr=5 -> R5=0, psr=3'b010.
- Then pcout=16'h3000, W_control_in=2, dr=6 -> R6=16'h3000, psr=3'b001.
REQ-036 Hold with no bypass: with R2=16'h00AA and sr1=dr=2, enable_writeback=1 and aluout=16'h0055:
- in the write cycle d1=16'h00AA;
- after the edge d1=16'h0055.
- Next cycle, enable_writeback=0 with aluout=16'hFFFF -> R2 and psr unchanged.
REQ-037 Reset mid-operation: after R1=16'h7FFF, assert reset together with enable_writeback=1, aluout=16'h8000, dr=1 -> R1=16'h0000, psr=3'b000.
REQ-038 Exhaustive write/read sweep: for dr=0..7 write data 16'hA000+dr, then read back all eight pairs via sr1 and sr2 -> each register holds its own value with no aliasing.
